// File: rtl/pb_debounce_toggle.sv
// Push-button conditioner: per channel a 2-flop synchroniser, a counter-based
// debounce FSM, a clean level, one-cycle press/release pulses and a toggle
// latch that flips on every accepted press. Channels are fully independent.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset, released synchronously
//   pb_in      raw active-high button pins (asynchronous, bouncy)
//   pb_level   debounced level, 1 = pressed
//   pb_press   one-cycle pulse on an accepted 0->1 transition
//   pb_release one-cycle pulse on an accepted 1->0 transition
//   led_toggle toggle state, flips on each pb_press
module pb_debounce_toggle #(
    parameter int unsigned N_BTN         = 3,
    parameter int unsigned STABLE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] pb_in,
    output logic [N_BTN-1:0] pb_level,
    output logic [N_BTN-1:0] pb_press,
    output logic [N_BTN-1:0] pb_release,
    output logic [N_BTN-1:0] led_toggle
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdleLow,
        StWaitHigh,
        StIdleHigh,
        StWaitLow
    } state_e;

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pb_in;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d;
        logic             press_q, press_d;
        logic             release_q, release_d;
        logic             toggle_q, toggle_d;
        logic             sync;

        assign sync = sync2_q[i];

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            toggle_d  = toggle_q;
            unique case (state_q)
                StIdleLow: begin
                    cnt_d = '0;
                    if (sync) state_d = StWaitHigh;
                end
                StWaitHigh: begin
                    if (!sync) begin
                        // Glitch: drop back and restart the full count next time.
                        state_d = StIdleLow;
                        cnt_d   = '0;
                    end else if (cnt_q == CntMax) begin
                        state_d  = StIdleHigh;
                        cnt_d    = '0;
                        level_d  = 1'b1;
                        press_d  = 1'b1;
                        toggle_d = ~toggle_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StIdleHigh: begin
                    cnt_d = '0;
                    if (!sync) state_d = StWaitLow;
                end
                StWaitLow: begin
                    if (sync) begin
                        state_d = StIdleHigh;
                        cnt_d   = '0;
                    end else if (cnt_q == CntMax) begin
                        state_d   = StIdleLow;
                        cnt_d     = '0;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdleLow;
                    cnt_d   = '0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= StIdleLow;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                toggle_q  <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                toggle_q  <= toggle_d;
            end
        end

        assign pb_level[i]   = level_q;
        assign pb_press[i]   = press_q;
        assign pb_release[i] = release_q;
        assign led_toggle[i] = toggle_q;
    end

endmodule
